// File: rtl/screen_pkg.sv
// Shared definitions for the screen controller: screen encodings, panel geometry
// and a few RGB565 colour constants used by the screen generators.
package screen_pkg;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    CTRL  = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } screen_e;

  localparam int unsigned WIDTH  = 96;
  localparam int unsigned HEIGHT = 64;

  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] YELLOW = 16'hFFE0;

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: emits a single-cycle press pulse once the raw level has been
// stably high for DEBOUNCE_CYCLES cycles. Holding the button yields one pulse.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   raw        : button level, already synchronised to clk
//   press      : one-cycle registered press pulse
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  logic [15:0] cnt_q, cnt_d;
  logic        press_q, press_d;

  always_comb begin
    cnt_d = '0;
    if (raw) begin
      cnt_d = (cnt_q == DEBOUNCE_CYCLES) ? cnt_q : cnt_q + 16'd1;
    end
    // Fire on the step that takes the counter to DEBOUNCE_CYCLES; saturation
    // keeps a held button from firing again.
    press_d = raw && (cnt_q == DEBOUNCE_CYCLES - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/screen_controller.sv
// Screen controller: turns the OLED pixel_index into registered (x,y), sequences
// title/control/play/game-over screens from debounced buttons, and registers the
// selected generator's colour back to the OLED driver.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   frame_begin         : start-of-frame pulse; screen changes commit only here
//   pixel_index         : row-major pixel number
//   btnC/U/L/R/D        : raw synchronised buttons
//   game_over           : pulse from game logic
//   *_data              : RGB565 from the four screen generators
//   x, y                : registered coordinates (latency 1)
//   oled_data           : registered colour (latency 2 from pixel_index)
//   screen_sel          : visible screen
//   start_game          : one-cycle pulse when the visible screen becomes PLAY
module screen_controller #(
  parameter int unsigned WIDTH           = 96,
  parameter int unsigned HEIGHT          = 64,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [11:0] IDLE_FRAMES     = 12'd600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  input  logic        btnC,
  input  logic        btnU,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnD,
  input  logic        game_over,
  input  logic [15:0] title_data,
  input  logic [15:0] ctrl_data,
  input  logic [15:0] play_data,
  input  logic [15:0] over_data,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic [15:0] oled_data,
  output logic [1:0]  screen_sel,
  output logic        start_game
);

  import screen_pkg::*;

  // press[0..4] = C, U, L, R, D
  logic [4:0] press;
  logic [4:0] raw_btn;

  assign raw_btn = {btnD, btnR, btnL, btnU, btnC};

  for (genvar i = 0; i < 5; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_btn[i]),
      .press(press[i])
    );
  end

  logic [6:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic [15:0] oled_q, oled_d;
  screen_e     pending_q, pending_d;
  screen_e     sel_q, sel_d;
  logic        start_q, start_d;
  logic [11:0] idle_q, idle_d;
  logic        any_press;

  assign any_press = |press;

  always_comb begin
    x_d = '0;
    y_d = '0;
    if (pixel_index < 13'(WIDTH * HEIGHT)) begin
      x_d = 7'(pixel_index % 13'(WIDTH));
      y_d = 6'(pixel_index / 13'(WIDTH));
    end
  end

  always_comb begin
    oled_d = BLACK;
    unique case (sel_q)
      TITLE: oled_d = title_data;
      CTRL:  oled_d = ctrl_data;
      PLAY:  oled_d = play_data;
      OVER:  oled_d = over_data;
    endcase
  end

  // Next-state logic runs on pending, so several transitions inside one frame
  // chain naturally and only the last result is shown at frame_begin.
  always_comb begin
    pending_d = pending_q;
    unique case (pending_q)
      TITLE: if (press[0]) pending_d = CTRL;
      CTRL: begin
        if (press[3])                  pending_d = PLAY;
        else if (press[2])             pending_d = TITLE;
        else if (idle_q == IDLE_FRAMES) pending_d = TITLE;
      end
      PLAY: if (game_over) pending_d = OVER;
      OVER: if (press[0]) pending_d = TITLE;
    endcase

    idle_d = idle_q;
    if (pending_q != CTRL || pending_d != CTRL || any_press) begin
      idle_d = '0;
    end else if (frame_begin && idle_q != IDLE_FRAMES) begin
      idle_d = idle_q + 12'd1;
    end

    sel_d   = frame_begin ? pending_q : sel_q;
    start_d = frame_begin && (pending_q == PLAY) && (sel_q != PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      oled_q    <= BLACK;
      pending_q <= TITLE;
      sel_q     <= TITLE;
      start_q   <= 1'b0;
      idle_q    <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      oled_q    <= oled_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      start_q   <= start_d;
      idle_q    <= idle_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign oled_data  = oled_q;
  assign screen_sel = sel_q;
  assign start_game = start_q;

endmodule

// File: doc/screen_controller.md
Name: screen_controller

Overview:
- Upstream/downstream glue around the per-screen pixel generators: converts OLED driver pixel_index into (x,y), sequences the game through title/control/play/game-over screens, and registers the selected screen's colour back to the OLED driver.
- Screen generators stay purely combinational (x,y in, oled_data out). This block owns all timing, button handling and screen selection.

Parameters:
- WIDTH, 96, OLED columns
- HEIGHT, 64, OLED rows
- DEBOUNCE_CYCLES, 16'd50000, cycles a raw button must be stably high before it counts as pressed
- IDLE_FRAMES, 12'd600, frames with no press on the control screen before auto-return to title

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_begin  in  1  one-cycle pulse from OLED driver at start of each frame
- pixel_index  in  13  current pixel, 0..6143, row-major
- btnC, btnU, btnL, btnR, btnD  in  1 each  raw button levels, already synchronised to clk
- game_over  in  1  one-cycle pulse from game logic
- title_data, ctrl_data, play_data, over_data  in  16 each  RGB565 from the four screen generators, driven from x,y
- x  out  7  registered column = pixel_index mod 96
- y  out  6  registered row = pixel_index / 96
- oled_data  out  16  registered RGB565 to OLED driver
- screen_sel  out  2  active screen: 0 TITLE, 1 CTRL, 2 PLAY, 3 OVER
- start_game  out  1  one-cycle pulse on entry to PLAY

Behaviour:
- Reset: x=0, y=0, oled_data=16'h0000, screen_sel=0, start_game=0, state TITLE, pending=TITLE, debounce and idle counters 0.
- Coordinate stage:
  - Register x,y from pixel_index each cycle, so latency is 1.
  - Out-of-range index (>=6144): x=0, y=0.
- Output stage:
  - oled_data is registered from the generator selected by screen_sel, one cycle after x,y, so total latency from pixel_index is 2.
  - TITLE->title_data, CTRL->ctrl_data, PLAY->play_data, OVER->over_data.
- Debounce, per button:
  - Counter increments while raw is high and saturates at DEBOUNCE_CYCLES; clears when raw is low.
  - Press pulse (1 cycle) fires when the counter reaches DEBOUNCE_CYCLES.
  - Holding a button produces exactly one pulse.
- FSM, evaluated on press pulses; the result is written to next_state:
  - TITLE: C -> CTRL.
  - CTRL: R -> PLAY; L -> TITLE; idle counter reaching IDLE_FRAMES -> TITLE. R has priority over L when both press in the same cycle.
  - PLAY: game_over -> OVER. game_over has priority over any button. Buttons are ignored in PLAY (game logic consumes them).
  - OVER: C -> TITLE.
  - btnU and btnD cause no transitions. Every non-listed press is ignored.
- Tear-free switching:
  - next_state is held in pending.
  - screen_sel updates to pending only in the cycle frame_begin=1.
  - Multiple transitions within one frame: the last one wins.
  - The FSM continues from pending, not from screen_sel.
- start_game pulses high for 1 cycle in the same cycle screen_sel changes to PLAY.
- Idle counter:
  - Counts frame_begin pulses while pending==CTRL.
  - Clears on any press pulse and on leaving CTRL.
  - Saturates at IDLE_FRAMES.
- Reset asserted mid-frame or mid-debounce: all state returns to reset values on that edge. No partial press is carried over.

Decomposition:
- Package screen_pkg: state encodings TITLE/CTRL/PLAY/OVER (2-bit), WIDTH/HEIGHT constants, colour constants BLACK/WHITE etc.
- One sub-module, btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, raw, press), instantiated 5x.
- Index-to-xy arithmetic and the FSM stay inline.

Test Plan:
- pixel_index=0, 95, 96, 6143, 6144 on consecutive cycles -> x,y one cycle later = (0,0), (95,0), (0,1), (95,63), (0,0).
- screen_sel=CTRL, ctrl_data=16'hFFE0, title_data=16'h0000 -> oled_data=16'hFFE0 two cycles after pixel_index is applied.
- Hold btnC high 3*DEBOUNCE_CYCLES in TITLE -> exactly one press. screen_sel stays 0 until the next frame_begin, then becomes 1. A btnC high for DEBOUNCE_CYCLES-1 cycles produces no change.
- In CTRL, btnR and btnL pulses land in the same cycle, then frame_begin -> screen_sel=2, start_game high exactly 1 cycle.
- In PLAY, game_over and btnC coincide -> screen_sel=3 at the next frame_begin. A further btnC followed by frame_begin -> screen_sel=0.
- In CTRL, no presses for IDLE_FRAMES frame_begin pulses -> screen_sel=0 at the following frame_begin. A btnU press at frame IDLE_FRAMES-1 restarts the count.
